present_encipher: RTL and testbench
===================================

# present_encipher

Iterative, one-round-per-cycle encryption core for the team's 16-bit PRESENT-style block cipher, with a 32-bit key. It is the forward-direction counterpart of `present_decipher`: it produces the ciphertext that `present_decipher` inverts, using the identical S-box, bit permutation, key schedule and round count. It sits between a plaintext source and any ciphertext consumer, using a start/done handshake.

## Interface
- `ROUNDS`, default 7: number of full rounds; the round counter is 4 bits wide, so 1 ≤ ROUNDS ≤ 15.
- `clk`  in  1  system clock; rising-edge active.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only while `busy`=0.
- `ptext`  in  16  plaintext; sampled on the accepting edge only.
- `key`  in  32  cipher key; sampled on the accepting edge only.
- `busy`  out  1  high while rounds are in progress.
- `done`  out  1  single-cycle pulse; `ctext` is valid from this cycle.
- `ctext`  out  16  ciphertext; holds its value until the next completion.

## Operation
- **Registers**
  - `state`[15:0] holds the block.
  - `K`[31:0] holds the key.
  - `rc`[3:0] is the round counter.
  - The FSM has two states, IDLE and RUN.
- **Round r (r = 1..ROUNDS)**, executed in this order:
  - Add round key: `state ^= K[31:16]`.
  - S-box on each nibble. Input 0..F maps to C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  - pLayer: bit i moves to bit (4·i mod 15) for i < 15; bit 15 stays at 15.
  - Key update:
    - Rotate K left by 7: `K = {K[24:0], K[31:25]}`.
    - Pass `K[31:28]` through the S-box.
    - XOR `K[10:7]` with r.
- **Final whitening:** `ctext = state ^ K[31:16]`, using the key left after ROUNDS updates.
- **IDLE**
  - `start`=1 loads `state`=`ptext`, `K`=`key` and `rc`=1, then moves to RUN.
  - `start`=0: everything holds.
- **RUN**
  - Each edge applies round `rc` to `state` and `K`, then increments `rc`.
  - On the edge where `rc`==ROUNDS, round ROUNDS is applied and whitened in the same cycle. That edge writes `ctext`, sets `done`=1, and returns the FSM to IDLE.
- **Sampling:** `start`, `ptext` and `key` are ignored while `busy`=1. Changes to `ptext` or `key` after the accepting edge have no effect.
- **Reset (asynchronous, valid at any time, including mid-RUN)**
  - Outputs clear to: `busy`=0, `done`=0, `ctext`=0.
  - Internal registers clear to: `state`=0, `K`=0, `rc`=0, FSM=IDLE.
  - An in-flight operation is discarded. No `done` is issued for it.
- **Decipher contract:** `present_decipher` applies the inverses in reverse order, with round keys in reverse order. The shared functions (S-box, pLayer, key update) must not diverge between the two modules.

## Timing
- Start is accepted at edge E0. `busy`=1 from E0 through the cycle before edge E_ROUNDS.
- `ctext` and `done`=1 appear after edge E_ROUNDS (edge 7 by default). Latency is ROUNDS cycles from the accepting edge.
- `busy` is registered. It is 1 exactly when the FSM is in RUN.
- `done`:
  - It is high for exactly one cycle, during which `busy`=0.
  - A `start` in the `done` cycle is accepted, so back-to-back throughput is one block per ROUNDS+1 cycles.
- `ctext` is unchanged between completions and after a `start` until the next `done`.
- With `start` held high continuously, a new block begins every ROUNDS+1 cycles.
- There is no combinational path from any input to any output.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `busy`=0, `done`=0, `ctext`=0 immediately, without waiting for a clock edge.
- **Single round:** `ptext`=0000, `key`=00000000, `start` pulse. After the first RUN edge, the `state` probe = FF00 and `K` = C0000080. `done` rises exactly 7 cycles after the accepting edge and lasts 1 cycle.
- **Golden model:** 200 random `ptext`/`key` pairs against the bench's golden model → `ctext` matches every case. Each `ctext` fed to `present_decipher` with the same key returns the original `ptext`.
- **Ignored inputs while busy:** pulse `start` with new `ptext`/`key` at the 3rd RUN cycle → ignored. The result equals the first operation's and only one `done` occurs.
- **Back-to-back:** hold `start`=1 with a new `ptext` on each accept → a `done` every 8 cycles, each `ctext` correct. The accept happens in the `done` cycle.
- **Reset mid-operation:** assert `rst` at round 4 and then release it → no `done`, `ctext`=0. A fresh `start` completes normally in 7 cycles.

Source files
------------

// File: rtl/present_encipher.sv
// present_encipher: iterative 16-bit PRESENT-style encryption core with a 32-bit key,
// one round per clock, start/done handshake.
`default_nettype none

module present_encipher #(
    parameter int ROUNDS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] ptext,
    input  logic [31:0] key,
    output logic        busy,
    output logic        done,
    output logic [15:0] ctext
);

    localparam logic [3:0] LAST_RC = 4'(ROUNDS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    fsm_t        fsm;
    fsm_t        fsm_next;
    logic [15:0] state;
    logic [31:0] k_reg;
    logic [3:0]  rc;

    logic        load;
    logic        step;
    logic        finish;
    logic [15:0] round_state;
    logic [31:0] round_key;
    logic [15:0] whitened;

    // These three functions are shared bit-for-bit with present_decipher.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'hC;
            4'h1:    y = 4'h5;
            4'h2:    y = 4'h6;
            4'h3:    y = 4'hB;
            4'h4:    y = 4'h9;
            4'h5:    y = 4'h0;
            4'h6:    y = 4'hA;
            4'h7:    y = 4'hD;
            4'h8:    y = 4'h3;
            4'h9:    y = 4'hE;
            4'hA:    y = 4'hF;
            4'hB:    y = 4'h8;
            4'hC:    y = 4'h4;
            4'hD:    y = 4'h7;
            4'hE:    y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [15:0] sub_layer(input logic [15:0] x);
        logic [15:0] y;
        y = '0;
        for (int n = 0; n < 4; n++) begin
            y[n*4 +: 4] = sbox(x[n*4 +: 4]);
        end
        return y;
    endfunction

    // Bit i lands on bit 4*i mod 15; bit 15 is a fixed point.
    function automatic logic [15:0] p_layer(input logic [15:0] x);
        logic [15:0] y;
        y     = '0;
        y[15] = x[15];
        for (int i = 0; i < 15; i++) begin
            y[(4 * i) % 15] = x[i];
        end
        return y;
    endfunction

    function automatic logic [31:0] key_update(input logic [31:0] k, input logic [3:0] r);
        logic [31:0] kr;
        kr        = {k[24:0], k[31:25]};
        kr[31:28] = sbox(kr[31:28]);
        kr[10:7]  = kr[10:7] ^ r;
        return kr;
    endfunction

    assign round_state = p_layer(sub_layer(state ^ k_reg[31:16]));
    assign round_key   = key_update(k_reg, rc);
    assign whitened    = round_state ^ round_key[31:16];

    always_comb begin
        fsm_next = fsm;
        load     = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        case (fsm)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    fsm_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (rc == LAST_RC) begin
                    finish   = 1'b1;
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm   <= IDLE;
            state <= '0;
            k_reg <= '0;
            rc    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ctext <= '0;
        end else begin
            fsm  <= fsm_next;
            busy <= (fsm_next == RUN);
            done <= finish;
            if (load) begin
                state <= ptext;
                k_reg <= key;
                rc    <= 4'd1;
            end else if (step) begin
                state <= round_state;
                k_reg <= round_key;
                rc    <= rc + 4'd1;
            end
            if (finish) begin
                ctext <= whitened;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_present_encipher.sv
// Self-checking bench for present_encipher: vector table, scoreboard with golden
// encipher/decipher model, and hand-written handshake/reset sequences.
`default_nettype none

module tb_present_encipher;

    localparam int R = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] ptext;
    logic [31:0] key;
    logic        busy;
    logic        done;
    logic [15:0] ctext;

    present_encipher #(.ROUNDS(R)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ptext (ptext),
        .key   (key),
        .busy  (busy),
        .done  (done),
        .ctext (ctext)
    );

    always #5 clk = ~clk;

    int     tests = 0;
    int     fails = 0;
    int     done_count = 0;
    longint cyc = 0;
    logic   prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] pt;
        logic [31:0] k;
        logic [15:0] ct;
    } sb_t;
    sb_t sb[$];

    // ---------------- golden model ----------------
    function automatic logic [3:0] m_s(input logic [3:0] x);
        logic [63:0] t;
        t = 64'h2174_8FE3_DA09_B65C;
        return t[x*4 +: 4];
    endfunction

    function automatic logic [3:0] m_si(input logic [3:0] x);
        for (int v = 0; v < 16; v++) begin
            if (m_s(4'(v)) == x) return 4'(v);
        end
        return 4'h0;
    endfunction

    function automatic int m_dest(input int i);
        return (i == 15) ? 15 : (4 * i) % 15;
    endfunction

    function automatic logic [15:0] m_p(input logic [15:0] x);
        logic [15:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[m_dest(i)] = x[i];
        return y;
    endfunction

    function automatic logic [15:0] m_pi(input logic [15:0] x);
        logic [15:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[i] = x[m_dest(i)];
        return y;
    endfunction

    function automatic logic [15:0] m_sub(input logic [15:0] x, input bit inv);
        logic [15:0] y;
        for (int n = 0; n < 4; n++) y[n*4 +: 4] = inv ? m_si(x[n*4 +: 4]) : m_s(x[n*4 +: 4]);
        return y;
    endfunction

    function automatic logic [31:0] m_ku(input logic [31:0] k, input int r);
        logic [31:0] t;
        logic [3:0]  rr;
        rr = 4'(r);
        t = (k << 7) | (k >> 25);
        t[31:28] = m_s(t[31:28]);
        t[10:7] = t[10:7] ^ rr;
        return t;
    endfunction

    function automatic logic [15:0] m_enc(input logic [15:0] pt, input logic [31:0] k0);
        logic [15:0] s;
        logic [31:0] k;
        s = pt;
        k = k0;
        for (int r = 1; r <= R; r++) begin
            s = m_p(m_sub(s ^ k[31:16], 1'b0));
            k = m_ku(k, r);
        end
        return s ^ k[31:16];
    endfunction

    function automatic logic [15:0] m_dec(input logic [15:0] ct, input logic [31:0] k0);
        logic [31:0] ks[R+1];
        logic [15:0] s;
        ks[0] = k0;
        for (int r = 1; r <= R; r++) ks[r] = m_ku(ks[r-1], r);
        s = ct ^ ks[R][31:16];
        for (int r = R; r >= 1; r--) s = m_sub(m_pi(s), 1'b1) ^ ks[r-1][31:16];
        return s;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            done_count++;
            chk("done_busy_low", 64'(busy), 64'd0);
            chk("done_one_cycle", 64'(prev_done), 64'd0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: got done with ctext %0h expected no done", ctext);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_ctext", 64'(ctext), 64'(e.ct));
                chk("sb_decipher", 64'(m_dec(ctext, e.k)), 64'(e.pt));
            end
        end
        prev_done = done;
    end

    // Call at a negedge with busy low; returns at accepting edge + 1.
    task automatic issue(input logic [15:0] pt, input logic [31:0] k, input bit push);
        sb_t e;
        start = 1'b1;
        ptext = pt;
        key   = k;
        if (push) begin
            e.pt = pt;
            e.k  = k;
            e.ct = m_enc(pt, k);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        ptext = 16'($urandom);
        key   = $urandom;
    endtask

    // Counts rising edges until done is seen; returns at the negedge of the done cycle.
    task automatic wait_done(output int n);
        n = 0;
        forever begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) return;
            if (n > 40) begin
                tests++;
                fails++;
                $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
                return;
            end
        end
    endtask

    typedef struct {
        logic [15:0] pt;
        logic [31:0] k;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        int pushed;
        int dones;
        int guard;
        longint last_done;
        bit chk_accept;

        vecs[0] = '{16'h0000, 32'h0000_0000, 16'h0};
        vecs[1] = '{16'hFFFF, 32'hFFFF_FFFF, 16'h0};
        vecs[2] = '{16'hAAAA, 32'h5555_5555, 16'h0};
        vecs[3] = '{16'h1234, 32'hDEAD_BEEF, 16'h0};
        vecs[4] = '{16'h8001, 32'h0000_0001, 16'h0};
        vecs[5] = '{16'h0000, 32'h8000_0000, 16'h0};
        foreach (vecs[i]) vecs[i].exp = m_enc(vecs[i].pt, vecs[i].k);

        rst = 1'b1; start = 1'b0; ptext = '0; key = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_ctext", 64'(ctext), 64'd0);
        rst = 1'b0;

        // Single round probe and latency
        @(negedge clk);
        issue(16'h0000, 32'h0000_0000, 1'b1);
        chk("busy_after_accept", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        chk("round1_state", 64'(dut.state), 64'h0000_FF00);
        chk("round1_key", 64'(dut.k_reg), 64'hC000_0080);
        wait_done(n);
        chk("single_latency", 64'(n + 1), 64'(R));
        @(negedge clk);
        chk("done_drops", 64'(done), 64'd0);
        chk("ctext_holds", 64'(ctext), 64'(m_enc(16'h0, 32'h0)));

        // Table vectors
        foreach (vecs[i]) begin
            @(negedge clk);
            issue(vecs[i].pt, vecs[i].k, 1'b1);
            wait_done(n);
            chk("vec_latency", 64'(n), 64'(R));
            chk("vec_ctext", 64'(ctext), 64'(vecs[i].exp));
        end

        // Random vectors, each issued in the previous done cycle
        for (int i = 0; i < 200; i++) begin
            issue(16'($urandom), $urandom, 1'b1);
            wait_done(n);
        end

        // Inputs ignored while busy
        @(negedge clk);
        issue(16'hC0DE, 32'h1357_9BDF, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        d0 = done_count;
        start = 1'b1; ptext = 16'hBAD0; key = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        chk("ignored_ctext", 64'(ctext), 64'(m_enc(16'hC0DE, 32'h1357_9BDF)));
        repeat (20) @(negedge clk);
        chk("ignored_one_done", 64'(done_count - d0), 64'd1);

        // Back-to-back with start held high
        start = 1'b1; pushed = 0; dones = 0; guard = 0; last_done = 0; chk_accept = 1'b0;
        while (dones < 5 && guard < 200) begin
            if (done) begin
                dones++;
                if (dones > 1) chk("b2b_interval", 64'(cyc - last_done), 64'(R + 1));
                last_done = cyc;
                chk_accept = (pushed < 5);
            end
            if (!busy && pushed < 5) begin
                sb_t e;
                ptext = 16'($urandom);
                key   = $urandom;
                e.pt = ptext; e.k = key; e.ct = m_enc(ptext, key);
                sb.push_back(e);
                pushed++;
            end
            @(posedge clk);
            #1;
            if (chk_accept) begin
                chk("b2b_accept_in_done", 64'(busy), 64'd1);
                chk_accept = 1'b0;
            end
            if (pushed == 5) start = 1'b0;
            @(negedge clk);
            guard++;
        end
        chk("b2b_done_count", 64'(dones), 64'd5);

        // Reset in the middle of an operation
        @(negedge clk);
        issue(16'h7777, 32'hCAFE_F00D, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_ctext", 64'(ctext), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        d0 = done_count;
        repeat (15) @(negedge clk);
        chk("midreset_no_done", 64'(done_count - d0), 64'd0);
        chk("midreset_ctext_held", 64'(ctext), 64'd0);
        issue(16'h4242, 32'h0BAD_CAFE, 1'b1);
        wait_done(n);
        chk("post_reset_latency", 64'(n), 64'(R));

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
